// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
// Priority per register: flush, then issue (set), then writeback (clear), then hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic                 sb_flush,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [DEPTH-1:0]     busy,
    output logic [CW-1:0]        busy_cnt
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic [DEPTH-1:0] wr_hit_s;
    logic [CW-1:0]    busy_cnt_r;
    logic [CW-1:0]    cnt_nxt_s;

    // Decode which registers receive a writeback this cycle.
    always_comb begin
        wr_hit_s = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                wr_hit_s[wr_addr[p*AW +: AW]] = 1'b1;
            end else begin
                wr_hit_s = wr_hit_s;
            end
        end
    end

    // Next busy bits by priority, and the population count of the result.
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (sb_flush) begin
                busy_nxt_s[r] = 1'b0;
            end else if (sb_set && (sb_set_addr == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (wr_hit_s[r]) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
        busy_nxt_s[AW'(ZERO_REG)] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            cnt_nxt_s = cnt_nxt_s + CW'(busy_nxt_s[r]);
        end
    end

    // Busy bits and count update together so they always agree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = busy_cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_set_addr,
    input  logic                   sb_flush,
    output logic [AW:0]            busy_cnt
);

    logic [XLEN-1:0]  rf_r [DEPTH];
    logic [DEPTH-1:0] busy_s;

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .AW     (AW),
        .CW     (AW + 1)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy_s),
        .busy_cnt    (busy_cnt)
    );

    // Data array; ascending port order lets the highest enabled port win a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_r[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
                    rf_r[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports; x0 and reset force zero data and not-busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!reset || (rd_addr[i*AW +: AW] == AW'(ZERO_REG))) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end else begin
                rd_data[i*XLEN +: XLEN] = rf_r[rd_addr[i*AW +: AW]];
                rd_busy[i]              = busy_s[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                        rd_busy[i] = sb_set && (sb_set_addr == rd_addr[i*AW +: AW]);
                    end else begin
                        rd_busy[i] = rd_busy[i];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, hand sequences and randomized model check.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   sb_set;
    logic [AW-1:0]          sb_set_addr;
    logic                   sb_flush;
    logic [AW:0]            busy_cnt;

    regfile_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
        .sb_set_addr(sb_set_addr), .sb_flush(sb_flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: architectural values and pending bits.
    logic [XLEN-1:0] rf_m [DEPTH];
    logic [DEPTH-1:0] busy_m;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        set;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) rf_m[r] = 32'd0;
        busy_m = 32'd0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] d;
        if (!reset || a == 5'd0) return 32'd0;
        d = rf_m[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) d = wr_data[p*XLEN +: XLEN];
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic b;
        if (!reset || a == 5'd0) return 1'b0;
        b = busy_m[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) b = sb_set && (sb_set_addr == a);
`endif
        return b;
    endfunction

    // Clock-edge effect: writebacks clear, issue sets, flush overrides all.
    task automatic model_edge();
        logic [31:0] nb;
        if (!reset) begin
            model_clear();
        end else begin
            nb = busy_m;
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p]) nb[wr_addr[p*AW +: AW]] = 1'b0;
            if (sb_set) nb[sb_set_addr] = 1'b1;
            if (sb_flush) nb = 32'd0;
            nb[0] = 1'b0;
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0)
                    rf_m[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            busy_m = nb;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NUM_RD; i++) begin
            chk("rnd_rd_data", rd_data[i*XLEN +: XLEN], exp_rd(rd_addr[i*AW +: AW]));
            chk("rnd_rd_busy", 32'(rd_busy[i]), 32'(exp_busy(rd_addr[i*AW +: AW])));
        end
        chk("rnd_busy_cnt", 32'(busy_cnt), reset ? 32'($countones(busy_m)) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 2'b00; sb_set = 1'b0; sb_flush = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'b01, 5'd3, 32'hAAAA_AAAA, 5'd0, 32'd0,    1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 32'hAAAA_AAAA, 32'd0,          1'b0, 1'b0, 6'd0};
        tbl[1]  = '{2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'd0,    1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 32'd0,          32'hAAAA_AAAA, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{2'b11, 5'd7, 32'h0000_1111, 5'd7, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 32'h0000_2222, 32'hAAAA_AAAA, 1'b0, 1'b0, 6'd0};
        tbl[3]  = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'd0,          32'h0000_2222, 1'b1, 1'b0, 6'd1};
        tbl[4]  = '{2'b01, 5'd9, 32'h0000_0099, 5'd0, 32'd0,    1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 32'h0000_0099, 32'd0,          1'b1, 1'b0, 6'd1};
        tbl[5]  = '{2'b10, 5'd0, 32'd0,         5'd9, 32'h9A,   1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 32'h0000_009A, 32'd0,          1'b0, 1'b0, 6'd0};
        tbl[6]  = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd1, 1'b0, 5'd1, 5'd0, 32'd0,          32'd0,          1'b1, 1'b0, 6'd1};
        tbl[7]  = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd2, 1'b0, 5'd2, 5'd1, 32'd0,          32'd0,          1'b1, 1'b1, 6'd2};
        tbl[8]  = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd4, 1'b0, 5'd4, 5'd2, 32'd0,          32'd0,          1'b1, 1'b1, 6'd3};
        tbl[9]  = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd6, 1'b1, 5'd6, 5'd4, 32'd0,          32'd0,          1'b0, 1'b0, 6'd0};
        tbl[10] = '{2'b00, 5'd0, 32'd0,         5'd0, 32'd0,    1'b1, 5'd0, 1'b0, 5'd0, 5'd1, 32'd0,          32'd0,          1'b0, 1'b0, 6'd0};

        // Reset held with a write and an issue pending.
        model_clear();
        reset = 1'b0;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEAD_BEEF};
        sb_set = 1'b1; sb_set_addr = 5'd5; sb_flush = 1'b0;
        rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        step();
        #1;
        chk("rst_rd_data0", rd_data[31:0], 32'd0);
        chk("rst_rd_data1", rd_data[63:32], 32'd0);
        chk("rst_rd_busy", 32'(rd_busy), 32'd0);
        chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        step();
        reset = 1'b1;
        idle();
        #1;
        chk("post_rst_x5", rd_data[31:0], 32'd0);
        chk("post_rst_busy5", 32'(rd_busy[0]), 32'd0);
        step();

        // Directed vectors: apply one cycle of operations, then read back while idle.
        for (int k = 0; k < 11; k++) begin
            wr_en = tbl[k].we;
            wr_addr = {tbl[k].wa1, tbl[k].wa0};
            wr_data = {tbl[k].wd1, tbl[k].wd0};
            sb_set = tbl[k].set; sb_set_addr = tbl[k].sa; sb_flush = tbl[k].fl;
            #1;
            step();
            idle();
            rd_addr = {tbl[k].ra1, tbl[k].ra0};
            #1;
            chk($sformatf("vec%0d_rd_data0", k), rd_data[31:0], tbl[k].ed0);
            chk($sformatf("vec%0d_rd_data1", k), rd_data[63:32], tbl[k].ed1);
            chk($sformatf("vec%0d_rd_busy0", k), 32'(rd_busy[0]), 32'(tbl[k].eb0));
            chk($sformatf("vec%0d_rd_busy1", k), 32'(rd_busy[1]), 32'(tbl[k].eb1));
            chk($sformatf("vec%0d_busy_cnt", k), 32'(busy_cnt), 32'(tbl[k].ecnt));
            step();
        end

        // Same-cycle write and read of x10, first without then with an issue to x10.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h5555_5555};
        rd_addr = {5'd10, 5'd10};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_cycle", rd_data[31:0], 32'h5555_5555);
`else
        chk("nobyp_same_cycle", rd_data[31:0], 32'd0);
`endif
        chk("byp_busy_a", 32'(rd_busy[0]), 32'd0);
        step();
        idle();
        #1;
        chk("byp_next_cycle", rd_data[31:0], 32'h5555_5555);
        step();
        wr_en = 2'b01; wr_data = {32'd0, 32'h6666_6666};
        sb_set = 1'b1; sb_set_addr = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_set_data", rd_data[63:32], 32'h6666_6666);
        chk("byp_set_busy", 32'(rd_busy[1]), 32'd1);
`else
        chk("nobyp_set_data", rd_data[63:32], 32'h5555_5555);
        chk("nobyp_set_busy", 32'(rd_busy[1]), 32'd0);
`endif
        step();
        idle();
        #1;
        chk("set_win_data", rd_data[63:32], 32'h6666_6666);
        chk("set_win_busy", 32'(rd_busy[1]), 32'd1);
        chk("set_win_cnt", 32'(busy_cnt), 32'd1);
        sb_flush = 1'b1;
        step();
        idle();

        // Randomized traffic on a narrow address range, with occasional async reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                model_clear();
            end else begin
                reset = 1'b1;
            end
            wr_en = 2'($urandom_range(0, 3));
            wr_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wr_data = {32'($urandom), 32'($urandom)};
            sb_set = ($urandom_range(0, 2) == 0);
            sb_set_addr = 5'($urandom_range(0, 15));
            sb_flush = ($urandom_range(0, 24) == 0);
            rd_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            #1;
            check_model();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I register file.
- Adds configurable width, depth, read-port count and write-port count.
- Adds a per-register scoreboard of pending writes, which the decode stage uses for hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear) in the 5-stage pipeline.

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 1, number of synchronous write ports; range 1..4.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data per port.
- rd_busy  out  NUM_RD  scoreboard bit of each read address.
- wr_en  in  NUM_WR  write enable per write port.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- sb_set  in  1  mark sb_set_addr as pending (instruction issued with a destination).
- sb_set_addr  in  AW  destination being issued.
- sb_flush  in  1  synchronous clear of all scoreboard bits (pipeline flush).
- busy_cnt  out  $clog2(DEPTH)+1  number of registers currently pending.

Behaviour:
- Reset (reset low, asynchronous):
  - all registers cleared to 0; all scoreboard bits cleared; busy_cnt = 0.
  - rd_data = 0 and rd_busy = 0 for every port while reset is held.
  - Reset asserted mid-operation discards every in-flight write and scoreboard update of that cycle.
- Register 0:
  - writes to address 0 are ignored.
  - reads of address 0 always return 0 with rd_busy = 0.
  - sb_set with address 0 has no effect.
- Write, on rising edge: for each port p with wr_en[p] = 1, write wr_data[p] to rf[wr_addr[p]].
  - When several enabled ports target the same address, the highest-index port wins.
- Scoreboard, on rising edge, per register r != 0, in this priority:
  1. sb_flush = 1: bit cleared, regardless of any set or write in the same cycle.
  2. sb_set = 1 and sb_set_addr = r: bit set; set wins over a same-cycle write to r, because a newer writer is in flight.
  3. Any enabled write port addresses r: bit cleared.
  4. Otherwise the bit holds.
- busy_cnt: registered population count of scoreboard bits, updated the same edge as the bits, so it is consistent with them one cycle after any event. It never exceeds DEPTH-1.
- Reads: combinational from rf, zero latency.
- Without the bypass feature, a read of an address being written this cycle returns the old value; the new value is visible from the next cycle.
- Out-of-range addresses cannot occur, since DEPTH = 2^AW.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled write port this cycle returns that port's wr_data, using the highest matching index, with no wait for the edge.
  - rd_busy for that port reads 0 unless sb_set targets the same address in the same cycle, in which case it reads 1.
  - Address 0 is never bypassed.
- Undefined: no forwarding logic; reads and rd_busy reflect registered state only, and the pipeline's forwarding unit covers the hazard.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/DEPTH constants.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef xlen_t.
  - the constant ZERO_REG = '0.
- One natural sub-module, regfile_scoreboard: busy bits, set/clear/flush priority and busy_cnt.
- The data array and bypass mux stay in regfile_mp.

Test Plan:
1. Reset: hold reset low with wr_en=1, wr_addr=5, wr_data=32'hDEAD_BEEF -> every rd_data=0, rd_busy=0, busy_cnt=0; after release, a read of x5 returns 0.
2. Basic write/read: write x3=32'hAAAA_AAAA, then read x3 on port 0 and x0 on port 1 the next cycle -> 32'hAAAA_AAAA and 0; a write of x0=32'h1234 leaves x0 reading 0.
3. Multi-port conflict (NUM_WR=2): both ports write x7 with 32'h1111 and 32'h2222 -> x7 reads 32'h2222.
4. Scoreboard: sb_set x9 -> rd_busy=1 and busy_cnt=1 the next cycle.
   - Then same-cycle sb_set x9 with a write to x9 -> x9 stays busy.
   - Then a lone write to x9 -> busy clears and busy_cnt=0.
5. Flush: set x1, x2, x4 on consecutive cycles (busy_cnt=3), then sb_flush with sb_set x6 -> all bits 0 and busy_cnt=0.
6. Bypass: write x10=32'h5555_5555 while reading x10 in the same cycle.
   - With REGFILE_BYPASS_EN: 32'h5555_5555 and rd_busy=0 in that cycle.
   - Without it: old value that cycle, new value the next.
